// File: rtl/div_seq.sv
// Sequential signed divider: 64-bit dividend / 32-bit divisor using restoring
// shift-subtract on magnitudes, one quotient bit per clock, then sign fix-up.
module div_seq #(
    parameter int N = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           muordi,
    input  logic [N-1:0]   opera1,
    input  logic [2*N-1:0] opera2,
    output logic [2*N-1:0] result,
    output logic           valid,
    output logic           busy,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DIVIDE = 3'd2,
        S_SIGN   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    function automatic logic [N-1:0] neg_n(input logic [N-1:0] v);
        return ~v + {{(N-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*N-1:0] neg_2n(input logic [2*N-1:0] v);
        return ~v + {{(2*N-1){1'b0}}, 1'b1};
    endfunction

    state_t         state_r;
    logic [N-1:0]   divisor_r;
    logic [2*N-1:0] dividend_r;
    logic [N-1:0]   dvs_mag_r;
    logic [N-1:0]   rem_r;
    logic [N-1:0]   quo_r;
    logic [CW-1:0]  count_r;
    logic           qsign_r;
    logic           rsign_r;
    logic [2*N-1:0] result_r;
    logic           valid_r;
    logic           busy_r;
    logic           dbz_r;
    logic           ovf_r;

    logic [N-1:0]   dvs_abs_s;
    logic [2*N-1:0] dnd_abs_s;
    logic [N:0]     rem_shift_s;
    logic [N:0]     trial_s;
    logic           qbit_s;
    logic [N-1:0]   rem_next_s;
    logic [N-1:0]   quo_fix_s;
    logic [N-1:0]   rem_fix_s;
    logic           q_ovf_s;

    // Magnitudes, one restoring step, and the signed fix-up of the final magnitudes.
    always_comb begin
        dvs_abs_s   = divisor_r[N-1] ? neg_n(divisor_r) : divisor_r;
        dnd_abs_s   = dividend_r[2*N-1] ? neg_2n(dividend_r) : dividend_r;
        rem_shift_s = {rem_r, quo_r[N-1]};
        // rem < |divisor| always holds, so N+1 bits keep the trial sign exact.
        trial_s     = rem_shift_s - {1'b0, dvs_mag_r};
        qbit_s      = ~trial_s[N];
        if (qbit_s) begin
            rem_next_s = trial_s[N-1:0];
        end else begin
            rem_next_s = rem_shift_s[N-1:0];
        end
        quo_fix_s = qsign_r ? neg_n(quo_r) : quo_r;
        rem_fix_s = rsign_r ? neg_n(rem_r) : rem_r;
        if (qsign_r) begin
            q_ovf_s = (quo_r > {1'b1, {(N-1){1'b0}}});
        end else begin
            q_ovf_s = quo_r[N-1];
        end
    end

    // Control FSM with registered result and flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            divisor_r  <= {N{1'b0}};
            dividend_r <= {(2*N){1'b0}};
            dvs_mag_r  <= {N{1'b0}};
            rem_r      <= {N{1'b0}};
            quo_r      <= {N{1'b0}};
            count_r    <= {CW{1'b0}};
            qsign_r    <= 1'b0;
            rsign_r    <= 1'b0;
            result_r   <= {(2*N){1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            dbz_r      <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start && muordi) begin
                        divisor_r  <= opera1;
                        dividend_r <= opera2;
                        valid_r    <= 1'b0;
                        dbz_r      <= 1'b0;
                        ovf_r      <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    qsign_r   <= dividend_r[2*N-1] ^ divisor_r[N-1];
                    rsign_r   <= dividend_r[2*N-1];
                    dvs_mag_r <= dvs_abs_s;
                    if (dvs_abs_s == {N{1'b0}}) begin
                        result_r <= {(2*N){1'b1}};
                        dbz_r    <= 1'b1;
                        valid_r  <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= S_DONE;
                    end else if (dnd_abs_s[2*N-1:N] >= dvs_abs_s) begin
                        result_r <= {(2*N){1'b1}};
                        ovf_r    <= 1'b1;
                        valid_r  <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= S_DONE;
                    end else begin
                        rem_r   <= dnd_abs_s[2*N-1:N];
                        quo_r   <= dnd_abs_s[N-1:0];
                        count_r <= {CW{1'b0}};
                        state_r <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    rem_r   <= rem_next_s;
                    quo_r   <= {quo_r[N-2:0], qbit_s};
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    if (count_r == CW'(N-1)) begin
                        state_r <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    if (q_ovf_s) begin
                        ovf_r    <= 1'b1;
                        result_r <= {(2*N){1'b1}};
                    end else begin
                        result_r <= {rem_fix_s, quo_fix_s};
                    end
                    valid_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= S_DONE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign result      = result_r;
    assign valid       = valid_r;
    assign busy        = busy_r;
    assign div_by_zero = dbz_r;
    assign overflow    = ovf_r;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: driver pushes reference results, a negedge
// monitor pops and compares on every rising valid.
module tb_div_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        muordi;
    logic [31:0] opera1;
    logic [63:0] opera2;
    logic [63:0] result;
    logic        valid;
    logic        busy;
    logic        div_by_zero;
    logic        overflow;

    int tests = 0;
    int fails = 0;
    logic [65:0] sb_q[$];
    logic [65:0] last_exp;

    div_seq #(.N(32)) dut (
        .clock(clock), .reset(reset), .start(start), .muordi(muordi),
        .opera1(opera1), .opera2(opera2), .result(result), .valid(valid),
        .busy(busy), .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {div_by_zero, overflow, result} from magnitudes with plain / and %.
    function automatic logic [65:0] ref_div(input logic [63:0] a, input logic [31:0] b);
        logic [63:0] ua, ub, uq, ur, q, r;
        logic [31:0] bn;
        logic        qneg;
        if (b == 32'd0) return {1'b1, 1'b0, 64'hFFFFFFFF_FFFFFFFF};
        ua   = a[63] ? -a : a;
        bn   = -b;
        ub   = {32'd0, (b[31] ? bn : b)};
        uq   = ua / ub;
        ur   = ua % ub;
        qneg = a[63] ^ b[31];
        if ((!qneg && uq > 64'h7FFFFFFF) || (qneg && uq > 64'h80000000))
            return {1'b0, 1'b1, 64'hFFFFFFFF_FFFFFFFF};
        q = qneg ? -uq : uq;
        r = a[63] ? -ur : ur;
        return {1'b0, 1'b0, r[31:0], q[31:0]};
    endfunction

    function automatic int ref_latency(input logic [63:0] a, input logic [31:0] b);
        logic [63:0] ua;
        logic [31:0] ub;
        ua = a[63] ? -a : a;
        ub = b[31] ? -b : b;
        return (b == 32'd0 || ua[63:32] >= ub) ? 1 : 34;
    endfunction

    // Monitor: compare every rising valid against the oldest expectation.
    initial begin
        logic valid_q;
        logic [65:0] e;
        valid_q = 1'b0;
        forever begin
            @(negedge clock);
            if (valid && !valid_q) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got result %h with empty scoreboard", result);
                end else begin
                    e = sb_q.pop_front();
                    check("result", {div_by_zero, overflow, result}, e);
                end
            end
            valid_q = valid;
        end
    end

    task automatic run_op(input logic [63:0] a, input logic [31:0] b,
                          input int glitch, input int abort);
        int  cyc;
        int  lat;
        bit  done;
        lat      = ref_latency(a, b);
        last_exp = ref_div(a, b);
        @(negedge clock);
        opera1 = b;
        opera2 = a;
        muordi = 1'b1;
        start  = 1'b1;
        sb_q.push_back(last_exp);
        @(posedge clock);
        #1;
        start  = 1'b0;
        opera1 = $urandom;
        opera2 = {$urandom, $urandom};
        check("valid_drop", {65'd0, valid}, 66'd0);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clock);
            #1;
            cyc++;
            start = (cyc == glitch);
            if (cyc == abort) begin
                reset = 1'b1;
                #1;
                check("abort_outputs", {div_by_zero, overflow, result},  66'd0);
                check("abort_status",  {64'd0, valid, busy}, 66'd0);
                void'(sb_q.pop_back());
                reset = 1'b0;
                return;
            end
            if (valid) done = 1'b1;
            else if (cyc == 1) check("busy_in_op", {65'd0, busy}, 66'd1);
        end
        start = 1'b0;
        check("latency", 66'(cyc), 66'(lat));
        check("busy_done", {65'd0, busy}, 66'd0);
    endtask

    initial begin
        logic signed [63:0] ra;
        logic [31:0]        rb;
        reset  = 1'b1;
        start  = 1'b0;
        muordi = 1'b0;
        opera1 = 32'd0;
        opera2 = 64'd0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_state", {div_by_zero, overflow, result}, 66'd0);
        check("reset_status", {64'd0, valid, busy}, 66'd0);
        reset = 1'b0;

        run_op(64'd100, 32'd7, 0, 0);
        check("ex_100_7", {div_by_zero, overflow, result}, {2'b00, 64'h00000002_0000000E});
        run_op(64'hFFFFFFFF_FFFFFF9C, 32'd7, 0, 0);
        check("ex_m100_7", {div_by_zero, overflow, result}, {2'b00, 64'hFFFFFFFE_FFFFFFF2});
        run_op(64'd100, 32'hFFFFFFF9, 0, 0);
        check("ex_100_m7", {div_by_zero, overflow, result}, {2'b00, 64'h00000002_FFFFFFF2});
        run_op(64'hFFFFFFFF_80000000, 32'd1, 0, 0);
        run_op(64'h00000000_80000000, 32'd1, 0, 0);
        check("ex_2p31_ovf", {div_by_zero, overflow, result}, {2'b01, 64'hFFFFFFFF_FFFFFFFF});
        run_op(64'h00000001_00000000, 32'd1, 0, 0);
        run_op(64'd12345, 32'd0, 0, 0);
        check("ex_dbz", {div_by_zero, overflow, result}, {2'b10, 64'hFFFFFFFF_FFFFFFFF});
        run_op(64'h80000000_00000000, 32'hFFFFFFFF, 0, 0);
        run_op(64'h80000000_00000000, 32'h80000000, 0, 0);
        run_op(64'd1, 32'h80000000, 0, 0);
        run_op(64'h00000003_7FFFFFF9 + 64'd6, 32'd7, 0, 0);
        run_op(64'h00000003_80000000, 32'd7, 0, 0);
        run_op(64'hFFFFFFFC_80000000, 32'd7, 0, 0);
        run_op(64'hFFFFFFFC_7FFFFFF9, 32'd7, 0, 0);

        // muordi=0 in DONE must leave everything untouched.
        @(negedge clock);
        muordi = 1'b0;
        start  = 1'b1;
        opera1 = 32'd3;
        opera2 = 64'd1000;
        repeat (3) @(posedge clock);
        #1;
        start = 1'b0;
        check("muordi0_hold", {div_by_zero, overflow, result}, last_exp);
        check("muordi0_status", {64'd0, valid, busy}, {64'd0, 2'b10});

        run_op(64'h00000000_7654321F, 32'd1000, 11, 0);
        run_op(64'd987654321, 32'd13, 0, 16);
        run_op(64'd100, 32'd7, 0, 0);

        for (int i = 0; i < 900; i++) begin
            ra = {$urandom, $urandom};
            ra = ra >>> $urandom_range(0, 40);
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            run_op(ra, rb, 0, 0);
        end

        repeat (3) @(negedge clock);
        check("sb_empty", 66'(sb_q.size()), 66'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
